note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Record/playback controller that sequences the dot-matrix display and buzzer datapath in playback mode.
- In RECORD it samples the live keypad note (value_input/tone_input) once per duration tick and run-length encodes it into an internal buffer of {value, tone, duration} entries.
- In PLAY it replays the buffer, driving state, value_play and tone_play into the display block. Those ports must keep their existing encodings: value 001..111 = do..si, 000 = rest; tone 00 low, 10 mid, 11 high.

Parameters:
- DEPTH, 32, number of buffer entries.
- DUR_W, 8, width of the per-entry duration field in ticks; maximum duration MAX = 2^DUR_W-1.
- TICK_DIV, 50000, clk cycles per duration tick (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- rec_start  in  1  single-cycle pulse: clear buffer and start recording.
- play_start  in  1  single-cycle pulse: start playback.
- stop  in  1  single-cycle pulse: end recording or playback.
- loop_en  in  1  level; 1 = restart playback from entry 0 after the last entry.
- value_input  in  3  live note value.
- tone_input  in  2  live note tone.
- state  out  1  1 only while in PLAY; selects the playback inputs of the display.
- value_play  out  3  current playback note value.
- tone_play  out  2  current playback tone.
- rec_active  out  1  1 while in RECORD.
- full  out  1  sticky; set when recording stopped because the buffer filled.
- note_count  out  $clog2(DEPTH+1)  number of valid buffer entries.

Behaviour:
- Reset: FSM=IDLE; state=0, value_play=000, tone_play=00, rec_active=0, full=0, note_count=0; tick counter=0. Buffer contents are don't-care.
- FSM states: IDLE, RECORD, PLAY. All outputs are registered.
- Command priority in one cycle: stop > rec_start > play_start.
- Commands accepted only as follows; all others are ignored:
  - rec_start: in IDLE only.
  - play_start: in IDLE only, and only if note_count>0.
  - stop: in RECORD or PLAY.
- Tick generator:
  - Counter runs 0..TICK_DIV-1; tick=1 in the cycle the counter equals TICK_DIV-1.
  - Counter clears to 0 on an accepted rec_start or play_start, so the first tick occurs exactly TICK_DIV cycles after the start cycle.
- Accepted rec_start: next FSM=RECORD; note_count<=0, full<=0, seg_dur<=0.
- RECORD, on each tick, sampling value_input/tone_input:
  - If seg_dur==0: seg<=input, seg_dur<=1.
  - Else if input==seg and seg_dur<MAX: seg_dur<=seg_dur+1.
  - Else: write {seg, seg_dur} to buffer[note_count], note_count++, seg<=input, seg_dur<=1.
  - If that write makes note_count==DEPTH: FSM->IDLE, full<=1, and the newly opened segment is discarded.
  - A rest (000) is recorded as an ordinary segment.
- stop in RECORD: if seg_dur>0 and note_count<DEPTH, commit the open segment; then FSM->IDLE.
- Accepted play_start: FSM->PLAY; idx<=0; value_play/tone_play <= buffer[0] note, visible the cycle after play_start; remaining<=buffer[0].dur; state<=1.
- PLAY, on each tick:
  - If remaining>1: remaining--.
  - Else advance: if idx+1<note_count, load entry idx+1; else if loop_en, load entry 0; else FSM->IDLE with state, value_play and tone_play set to 0.
  - An entry of duration d is therefore presented for exactly d*TICK_DIV cycles.
- stop in PLAY: the next cycle has state=0, value_play=000, tone_play=00; buffer and note_count are kept.
- Outside PLAY, value_play=000 and tone_play=00.
- Asynchronous rst mid-operation returns to the reset state immediately; the buffer is treated as empty (note_count=0).

Test Plan:
- Bench parameters: TICK_DIV=4, DEPTH=4, DUR_W=4 (MAX=15).
- Reset: assert rst mid-PLAY -> state=0, value_play=000, tone_play=00, rec_active=0, full=0, note_count=0 immediately.
- Record and play back:
  - Stimulus: rec_start; hold v=001, t=10 for 3 ticks, then v=011, t=00 for 2 ticks; stop.
  - Record result: note_count=2.
  - Then play_start with loop_en=0.
  - Playback: state=1 with 001/10 for 12 cycles, then 011/00 for 8 cycles, then state=0 and outputs 0.
- Full: rec_start; change the note on every tick for 5 ticks -> at the 5th tick note_count=4, full=1, rec_active=0; a following stop is ignored.
- Saturation: hold 101/11 for 17 ticks, then stop -> entries (101,11,15) and (101,11,2), note_count=2.
- Loop and stop mid-play: loop_en=1 with 2 entries -> after the last entry, entry 0 reappears on the next tick with no gap; stop mid-entry -> next cycle state=0, outputs 0, note_count unchanged.
- Ignored and simultaneous commands:
  - play_start with note_count=0 -> stays IDLE.
  - rec_start during PLAY -> no effect.
  - stop and play_start in the same cycle while IDLE -> stays IDLE.
  - stop and rec_start in the same cycle during RECORD -> stop wins, FSM IDLE.

Source files
------------

// File: rtl/note_sequencer.sv
// Record/playback note sequencer: run-length encodes the live keypad note once
// per duration tick and replays the stored entries to the display/buzzer path.
module note_sequencer #(
  parameter int DEPTH    = 32,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rec_start,
  input  logic                       play_start,
  input  logic                       stop,
  input  logic                       loop_en,
  input  logic [2:0]                 value_input,
  input  logic [1:0]                 tone_input,
  output logic                       state,
  output logic [2:0]                 value_play,
  output logic [1:0]                 tone_play,
  output logic                       rec_active,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] note_count
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NC_W  = $clog2(DEPTH + 1);

  localparam logic [DUR_W-1:0] MAX_DUR  = '1;
  localparam logic [DUR_W-1:0] ONE_DUR  = DUR_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [NC_W-1:0]  NC_FULL  = NC_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RECORD,
    PLAY
  } fsm_t;

  typedef struct packed {
    logic [2:0] value;
    logic [1:0] tone;
  } note_t;

  typedef struct packed {
    note_t            note;
    logic [DUR_W-1:0] dur;
  } entry_t;

  fsm_t             fsm;
  logic [CNT_W-1:0] cnt;
  entry_t           buffer [DEPTH];
  note_t            seg;
  logic [DUR_W-1:0] seg_dur;
  logic [IDX_W-1:0] idx;
  logic [DUR_W-1:0] remaining;

  logic             tick;
  logic             rec_acc;
  logic             play_acc;
  note_t            live;
  logic             seg_extends;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  entry_t           wr_data;
  logic [IDX_W-1:0] next_idx;
  logic             has_next;
  entry_t           first_entry;
  entry_t           next_entry;

  assign tick = (cnt == CNT_LAST);

  // Priority is judged on the raw pulses: a stop seen in IDLE still masks a
  // simultaneous start even though the stop itself does nothing there.
  assign rec_acc  = !stop && rec_start && (fsm == IDLE);
  assign play_acc = !stop && !rec_start && play_start && (fsm == IDLE) &&
                    (note_count != '0);

  assign live        = {value_input, tone_input};
  assign seg_extends = (live == seg) && (seg_dur != MAX_DUR);

  assign wr_addr  = note_count[IDX_W-1:0];
  assign wr_data  = {seg, seg_dur};
  assign next_idx = idx + IDX_W'(1);
  assign has_next = (NC_W'(idx) + NC_W'(1)) < note_count;

  assign first_entry = buffer[0];
  assign next_entry  = buffer[next_idx];

  // NOTE: every variable driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    wr_en = 1'b0;
    if (fsm == RECORD) begin
      if (stop) begin
        wr_en = (seg_dur != '0) && (note_count != NC_FULL);
      end else if (tick && (seg_dur != '0) && !seg_extends) begin
        wr_en = 1'b1;
      end
    end
  end

  // NOTE: the buffer is deliberately left without reset; note_count alone
  // defines which entries are valid, so stale contents are never replayed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buffer[wr_addr] <= wr_data;
    end
  end

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch below reads the values from before this clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      cnt        <= '0;
      state      <= 1'b0;
      value_play <= '0;
      tone_play  <= '0;
      rec_active <= 1'b0;
      full       <= 1'b0;
      note_count <= '0;
      seg        <= '0;
      seg_dur    <= '0;
      idx        <= '0;
      remaining  <= '0;
    end else begin
      if (rec_acc || play_acc || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (wr_en) begin
        note_count <= note_count + NC_W'(1);
      end

      case (fsm)
        IDLE: begin
          if (rec_acc) begin
            fsm        <= RECORD;
            rec_active <= 1'b1;
            note_count <= '0;
            full       <= 1'b0;
            seg_dur    <= '0;
          end else if (play_acc) begin
            fsm                     <= PLAY;
            state                   <= 1'b1;
            idx                     <= '0;
            {value_play, tone_play} <= first_entry.note;
            remaining               <= first_entry.dur;
          end
        end

        RECORD: begin
          if (stop) begin
            fsm        <= IDLE;
            rec_active <= 1'b0;
            seg_dur    <= '0;
          end else if (tick) begin
            if (seg_dur == '0) begin
              seg     <= live;
              seg_dur <= ONE_DUR;
            end else if (seg_extends) begin
              seg_dur <= seg_dur + ONE_DUR;
            end else begin
              seg     <= live;
              seg_dur <= ONE_DUR;
              // Filling the last slot ends recording; the segment just opened is dropped.
              if ((note_count + NC_W'(1)) == NC_FULL) begin
                fsm        <= IDLE;
                rec_active <= 1'b0;
                full       <= 1'b1;
                seg_dur    <= '0;
              end
            end
          end
        end

        PLAY: begin
          if (stop) begin
            fsm        <= IDLE;
            state      <= 1'b0;
            value_play <= '0;
            tone_play  <= '0;
          end else if (tick) begin
            if (remaining > ONE_DUR) begin
              remaining <= remaining - ONE_DUR;
            end else if (has_next) begin
              idx                     <= next_idx;
              {value_play, tone_play} <= next_entry.note;
              remaining               <= next_entry.dur;
            end else if (loop_en) begin
              idx                     <= '0;
              {value_play, tone_play} <= first_entry.note;
              remaining               <= first_entry.dur;
            end else begin
              fsm        <= IDLE;
              state      <= 1'b0;
              value_play <= '0;
              tone_play  <= '0;
            end
          end
        end

        default: begin
          fsm        <= IDLE;
          state      <= 1'b0;
          value_play <= '0;
          tone_play  <= '0;
          rec_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: playback outputs are checked
// cycle by cycle against a queue of expected {state, value, tone} samples.
module tb_note_sequencer;

  localparam int TD    = 4;
  localparam int DEPTH = 4;
  localparam int DUR_W = 4;

  logic       clk        = 1'b0;
  logic       rst        = 1'b0;
  logic       rec_start  = 1'b0;
  logic       play_start = 1'b0;
  logic       stop       = 1'b0;
  logic       loop_en    = 1'b0;
  logic [2:0] value_input = '0;
  logic [1:0] tone_input  = '0;
  logic       state;
  logic [2:0] value_play;
  logic [1:0] tone_play;
  logic       rec_active;
  logic       full;
  logic [2:0] note_count;

  typedef struct packed {
    logic       st;
    logic [2:0] v;
    logic [1:0] t;
  } obs_t;

  obs_t sb[$];
  obs_t got;
  obs_t exp_obs;
  int   n_cmp = 0;
  int   n_bad = 0;

  note_sequencer #(
    .DEPTH    (DEPTH),
    .DUR_W    (DUR_W),
    .TICK_DIV (TD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rec_start   (rec_start),
    .play_start  (play_start),
    .stop        (stop),
    .loop_en     (loop_en),
    .value_input (value_input),
    .tone_input  (tone_input),
    .state       (state),
    .value_play  (value_play),
    .tone_play   (tone_play),
    .rec_active  (rec_active),
    .full        (full),
    .note_count  (note_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input logic [2:0] v, input logic [1:0] t, input int ticks);
    value_input = v;
    tone_input  = t;
    step(ticks * TD);
  endtask

  task automatic pulse_rec();
    rec_start = 1'b1;
    step(1);
    rec_start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic push_exp(input logic st, input logic [2:0] v, input logic [1:0] t, input int n);
    for (int i = 0; i < n; i++) sb.push_back({st, v, t});
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++;
    if ({state, value_play, tone_play, rec_active, full, note_count} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %b want all zero",
               {state, value_play, tone_play, rec_active, full, note_count});
    end
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_play_empty();
    play_start = 1'b1;
    step(1);
    play_start = 1'b0;
    n_cmp++;
    if (state !== 1'b0) begin
      n_bad++;
      $display("FAIL play_empty_next: state got %b want 0", state);
    end
    step(3);
    n_cmp++;
    if (state !== 1'b0) begin
      n_bad++;
      $display("FAIL play_empty_later: state got %b want 0", state);
    end
  endtask

  task automatic test_record_play();
    pulse_rec();
    n_cmp++;
    if (rec_active !== 1'b1) begin
      n_bad++;
      $display("FAIL rec_active_on: got %b want 1", rec_active);
    end
    hold(3'b001, 2'b10, 3);
    hold(3'b011, 2'b00, 2);
    n_cmp++;
    if (note_count !== 3'd1) begin
      n_bad++;
      $display("FAIL rec_mid_count: got %0d want 1", note_count);
    end
    pulse_stop();
    n_cmp++;
    if (rec_active !== 1'b0 || note_count !== 3'd2) begin
      n_bad++;
      $display("FAIL rec_result: rec_active=%b count=%0d want 0/2", rec_active, note_count);
    end
    loop_en = 1'b0;
    play_start = 1'b1;
    step(1);
    play_start = 1'b0;
    push_exp(1'b1, 3'b001, 2'b10, 12);
    push_exp(1'b1, 3'b011, 2'b00, 8);
    push_exp(1'b0, 3'b000, 2'b00, 4);
    while (sb.size() > 0) begin
      got     = {state, value_play, tone_play};
      exp_obs = sb.pop_front();
      n_cmp++;
      if (got !== exp_obs) begin
        n_bad++;
        $display("FAIL playback: got %b want %b (%0d left)", got, exp_obs, sb.size());
      end
      step(1);
    end
  endtask

  task automatic test_stop_play_idle();
    stop       = 1'b1;
    play_start = 1'b1;
    step(1);
    stop       = 1'b0;
    play_start = 1'b0;
    n_cmp++;
    if (state !== 1'b0 || note_count !== 3'd2) begin
      n_bad++;
      $display("FAIL stop_play_idle: state=%b count=%0d want 0/2", state, note_count);
    end
  endtask

  task automatic test_full();
    pulse_rec();
    for (int i = 1; i <= 5; i++) begin
      hold(3'(i), 2'b00, 1);
      if (i == 4) begin
        n_cmp++;
        if (note_count !== 3'd3 || full !== 1'b0 || rec_active !== 1'b1) begin
          n_bad++;
          $display("FAIL full_tick4: count=%0d full=%b rec=%b want 3/0/1",
                   note_count, full, rec_active);
        end
      end
    end
    n_cmp++;
    if (note_count !== 3'd4 || full !== 1'b1 || rec_active !== 1'b0) begin
      n_bad++;
      $display("FAIL full_tick5: count=%0d full=%b rec=%b want 4/1/0",
               note_count, full, rec_active);
    end
    pulse_stop();
    n_cmp++;
    if (note_count !== 3'd4 || full !== 1'b1 || rec_active !== 1'b0 || state !== 1'b0) begin
      n_bad++;
      $display("FAIL full_stop_ignored: count=%0d full=%b rec=%b state=%b want 4/1/0/0",
               note_count, full, rec_active, state);
    end
  endtask

  task automatic test_saturation();
    pulse_rec();
    n_cmp++;
    if (full !== 1'b0 || note_count !== 3'd0) begin
      n_bad++;
      $display("FAIL sat_clear: full=%b count=%0d want 0/0", full, note_count);
    end
    hold(3'b101, 2'b11, 17);
    pulse_stop();
    n_cmp++;
    if (note_count !== 3'd2) begin
      n_bad++;
      $display("FAIL sat_count: got %0d want 2", note_count);
    end
    loop_en = 1'b0;
    play_start = 1'b1;
    step(1);
    play_start = 1'b0;
    push_exp(1'b1, 3'b101, 2'b11, (15 + 2) * TD);
    push_exp(1'b0, 3'b000, 2'b00, 3);
    while (sb.size() > 0) begin
      got     = {state, value_play, tone_play};
      exp_obs = sb.pop_front();
      n_cmp++;
      if (got !== exp_obs) begin
        n_bad++;
        $display("FAIL sat_playback: got %b want %b (%0d left)", got, exp_obs, sb.size());
      end
      step(1);
    end
  endtask

  task automatic test_loop_stop();
    pulse_rec();
    hold(3'b010, 2'b11, 1);
    hold(3'b110, 2'b10, 2);
    pulse_stop();
    n_cmp++;
    if (note_count !== 3'd2) begin
      n_bad++;
      $display("FAIL loop_rec_count: got %0d want 2", note_count);
    end
    loop_en = 1'b1;
    play_start = 1'b1;
    step(1);
    play_start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      push_exp(1'b1, 3'b010, 2'b11, 4);
      push_exp(1'b1, 3'b110, 2'b10, 8);
    end
    push_exp(1'b1, 3'b010, 2'b11, 2);
    while (sb.size() > 0) begin
      got     = {state, value_play, tone_play};
      exp_obs = sb.pop_front();
      n_cmp++;
      if (got !== exp_obs) begin
        n_bad++;
        $display("FAIL loop_playback: got %b want %b (%0d left)", got, exp_obs, sb.size());
      end
      step(1);
    end
    pulse_stop();
    n_cmp++;
    if ({state, value_play, tone_play} !== 6'd0 || note_count !== 3'd2) begin
      n_bad++;
      $display("FAIL loop_stop: out=%b count=%0d want 000000/2",
               {state, value_play, tone_play}, note_count);
    end
    loop_en = 1'b0;
  endtask

  task automatic test_rec_during_play();
    play_start = 1'b1;
    step(1);
    play_start = 1'b0;
    push_exp(1'b1, 3'b010, 2'b11, 4);
    push_exp(1'b1, 3'b110, 2'b10, 8);
    push_exp(1'b0, 3'b000, 2'b00, 3);
    for (int i = 0; sb.size() > 0; i++) begin
      got     = {state, value_play, tone_play};
      exp_obs = sb.pop_front();
      n_cmp++;
      if (got !== exp_obs) begin
        n_bad++;
        $display("FAIL rec_in_play: got %b want %b (%0d left)", got, exp_obs, sb.size());
      end
      rec_start = (i == 5);
      step(1);
    end
    rec_start = 1'b0;
    n_cmp++;
    if (rec_active !== 1'b0 || note_count !== 3'd2) begin
      n_bad++;
      $display("FAIL rec_in_play_after: rec=%b count=%0d want 0/2", rec_active, note_count);
    end
  endtask

  task automatic test_stop_rec_priority();
    pulse_rec();
    hold(3'b001, 2'b00, 1);
    step(2);
    stop      = 1'b1;
    rec_start = 1'b1;
    step(1);
    stop      = 1'b0;
    rec_start = 1'b0;
    n_cmp++;
    if (rec_active !== 1'b0 || note_count !== 3'd1) begin
      n_bad++;
      $display("FAIL stop_over_rec: rec=%b count=%0d want 0/1", rec_active, note_count);
    end
    step(2);
    n_cmp++;
    if (rec_active !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_over_rec_later: rec=%b want 0", rec_active);
    end
  endtask

  task automatic test_reset_mid_play();
    play_start = 1'b1;
    step(1);
    play_start = 1'b0;
    n_cmp++;
    if ({state, value_play, tone_play} !== {1'b1, 3'b001, 2'b00}) begin
      n_bad++;
      $display("FAIL pre_reset_play: got %b want 100100", {state, value_play, tone_play});
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({state, value_play, tone_play, rec_active, full, note_count} !== 11'd0) begin
      n_bad++;
      $display("FAIL async_reset: got %b want all zero",
               {state, value_play, tone_play, rec_active, full, note_count});
    end
    step(1);
    rst = 1'b0;
    step(2);
    n_cmp++;
    if (state !== 1'b0 || note_count !== 3'd0) begin
      n_bad++;
      $display("FAIL post_reset: state=%b count=%0d want 0/0", state, note_count);
    end
  endtask

  initial begin
    test_reset();
    test_play_empty();
    test_record_play();
    test_stop_play_idle();
    test_full();
    test_saturation();
    test_loop_stop();
    test_rec_during_play();
    test_stop_rec_priority();
    test_reset_mid_play();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
